// File: rtl/unidade_busca.sv
// Instruction fetch: one outstanding word request, result held until PCWrite; 2 cycles/instr at zero wait.
// Misaligned next-PC trapping is enabled by defining BUSCA_MISALIGN_CHECK_EN; otherwise target bits [1:0] are cleared.
module unidade_busca #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        PCWrite,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] pc,
  output logic        fetch_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef BUSCA_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
`endif

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        mem_req_q;
  logic        instr_valid_q;
  logic [31:0] next_sel_d;
  logic [31:0] pc_d;

  always_comb begin
    next_sel_d = branch_taken ? branch_target : (pc_q + 32'd4);
    pc_d       = next_sel_d & 32'hFFFF_FFFC;
  end

`ifdef BUSCA_MISALIGN_CHECK_EN
  logic fetch_err_q;
  logic misalign_d;

  assign misalign_d = (next_sel_d[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q   <= REQ;
          mem_req_q <= 1'b1;
        end
        REQ: begin
          if (mem_rvalid) begin
            instr_q       <= mem_rdata;
            state_q       <= HOLD;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (PCWrite) begin
            instr_valid_q <= 1'b0;
            // A misaligned target traps with pc left on the offending instruction.
            if (misalign_d) begin
              state_q     <= ERR;
              fetch_err_q <= 1'b1;
            end else begin
              pc_q      <= pc_d;
              state_q   <= REQ;
              mem_req_q <= 1'b1;
            end
          end
        end
        ERR: begin
          fetch_err_q   <= 1'b1;
          mem_req_q     <= 1'b0;
          instr_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fetch_err = fetch_err_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q   <= REQ;
          mem_req_q <= 1'b1;
        end
        REQ: begin
          if (mem_rvalid) begin
            instr_q       <= mem_rdata;
            state_q       <= HOLD;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (PCWrite) begin
            pc_q          <= pc_d;
            state_q       <= REQ;
            mem_req_q     <= 1'b1;
            instr_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fetch_err = 1'b0;
`endif

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign rd          = instr_q[11:7];
  assign funct3      = instr_q[14:12];
  assign rs1         = instr_q[19:15];
  assign rs2         = instr_q[24:20];
  assign funct7      = instr_q[31:25];

endmodule
